arithmetic_logic_seq: RTL and testbench



---
 rtl/instr_pack.sv | 27 ++
 rtl/alu_mul_iter.sv | 68 ++++++
 rtl/arithmetic_logic_seq.sv | 154 +++++++++++++++
 tb/tb_arithmetic_logic_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - shared ALU opcode, state and width definitions
//
// Purpose: opcode enum shared by the register-file decode and the ALU, the ALU
// sequencer state enum, and the default datapath width.
// Ports: none (package).
// Encodings 3'd7 of math_t are unused and are treated as illegal by the ALU.

package instr_pack;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        EQL  = 3'd2,
        EQLN = 3'd3,
        SHL  = 3'd4,
        SHR  = 3'd5,
        MUL  = 3'd6
    } math_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
//
// Purpose: computes a*b over WIDTH iterations. The start cycle performs
// iteration 0 from the live operands; the following WIDTH-1 busy cycles add the
// remaining partial products. finish is asserted combinationally during the
// last busy cycle, with product already holding the final value.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a multiply (ignored while busy)
//   a, b                operands, sampled on the start cycle only
//   busy                iterations 1..WIDTH-1 in progress
//   finish              last iteration happens at the end of this cycle
//   product             full 2*WIDTH product (valid while finish is high)

module alu_mul_iter import instr_pack::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 finish,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // cnt holds the index of the partial product being added this cycle
    assign finish  = busy && (cnt == CW'(WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= b >> 1;
            cnt    <= CW'(1);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (finish) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arithmetic_logic_seq.sv
// rtl/arithmetic_logic_seq.sv - clocked ALU with flags and optional iterative multiply
//
// Purpose: accepts one operation per in_valid/in_ready handshake and writes the
// result into r_out or s_out (chosen by dst). Single-cycle ops complete one
// cycle after accept; MUL (only when ALU_MUL_EN is defined) runs for WIDTH
// cycles with in_ready low. Without ALU_MUL_EN, MUL is reported as illegal.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_ready  request handshake
//   op, x, y, dst       opcode, operands, destination (0 = r_out, 1 = s_out)
//   r_out, s_out        result registers
//   done                one-cycle completion pulse, flags valid with it
//   carry, zero, err    carry/no-borrow/shifted-out bit, result == 0, illegal op

module arithmetic_logic_seq import instr_pack::*; #(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int EQ_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  math_t            op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             dst,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] s_out,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    alu_state_t       state;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_single;

`ifdef ALU_MUL_EN
    logic               mul_busy;
    logic               mul_finish;
    logic [2*WIDTH-1:0] mul_product;
    logic               dst_q;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && (op == MUL)),
        .a       (x),
        .b       (y),
        .busy    (mul_busy),
        .finish  (mul_finish),
        .product (mul_product)
    );

    assign in_ready = (state == IDLE) && !mul_busy;
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept = in_valid && in_ready;
    assign sum    = {1'b0, x} + {1'b0, y};
    // bit WIDTH of x + ~y + 1 is the no-borrow flag (x >= y unsigned)
    assign diff   = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);

    always_comb begin
        alu_res    = '0;
        alu_carry  = 1'b0;
        alu_single = 1'b1;
        case (op)
            ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            EQL:  alu_res = {{(WIDTH-1){1'b0}}, (x == y)};
            EQLN: alu_res = {{(WIDTH-1){1'b0}}, (x[EQ_BITS-1:0] == y[EQ_BITS-1:0])};
            SHL: begin
                alu_res   = {x[WIDTH-2:0], 1'b0};
                alu_carry = x[WIDTH-1];
            end
            SHR: begin
                alu_res   = {1'b0, x[WIDTH-1:1]};
                alu_carry = x[0];
            end
            // MUL and unused encodings are not single-cycle ops
            default: alu_single = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            r_out <= '0;
            s_out <= '0;
            done  <= 1'b0;
            carry <= 1'b0;
            zero  <= 1'b0;
            err   <= 1'b0;
`ifdef ALU_MUL_EN
            dst_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (alu_single) begin
                            if (dst) s_out <= alu_res;
                            else     r_out <= alu_res;
                            done  <= 1'b1;
                            carry <= alu_carry;
                            zero  <= (alu_res == '0);
                            err   <= 1'b0;
`ifdef ALU_MUL_EN
                        end else if (op == MUL) begin
                            dst_q <= dst;
                            state <= MUL_RUN;
`endif
                        end else begin
                            // illegal or compiled-out op: flag only, no write
                            done  <= 1'b1;
                            carry <= 1'b0;
                            zero  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                MUL_RUN: begin
                    if (mul_finish) begin
                        if (dst_q) s_out <= mul_product[WIDTH-1:0];
                        else       r_out <= mul_product[WIDTH-1:0];
                        done  <= 1'b1;
                        carry <= |mul_product[2*WIDTH-1:WIDTH];
                        zero  <= (mul_product[WIDTH-1:0] == '0);
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arithmetic_logic_seq.sv
// tb/tb_arithmetic_logic_seq.sv - self-checking bench for arithmetic_logic_seq

module tb_arithmetic_logic_seq;
    import instr_pack::*;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] s;
        logic       c;
        logic       z;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    math_t      op = ADD;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;
    logic       dst = 1'b0;
    logic [7:0] r_out;
    logic [7:0] s_out;
    logic       done;
    logic       carry;
    logic       zero;
    logic       err;

    exp_t       exp_q[$];
    logic [7:0] r_m = 8'h00;
    logic [7:0] s_m = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    arithmetic_logic_seq #(.WIDTH(8), .EQ_BITS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .x        (x),
        .y        (y),
        .dst      (dst),
        .r_out    (r_out),
        .s_out    (s_out),
        .done     (done),
        .carry    (carry),
        .zero     (zero),
        .err      (err)
    );

    function automatic exp_t observed();
        return {r_out, s_out, carry, zero, err};
    endfunction

    // Reference model: updates the model registers and pushes the expected outputs
    task automatic predict(input math_t o, input logic [7:0] a, input logic [7:0] b, input logic d);
        int         t;
        logic [7:0] v;
        logic       c;
        logic       legal;
        v = 8'h00;
        c = 1'b0;
        legal = 1'b1;
        case (o)
            ADD:  begin t = int'(a) + int'(b); v = 8'(t); c = (t > 255); end
            SUB:  begin v = a - b; c = (a >= b); end
            EQL:  v = (a == b) ? 8'h01 : 8'h00;
            EQLN: v = (a[4:0] == b[4:0]) ? 8'h01 : 8'h00;
            SHL:  begin v = a << 1; c = a[7]; end
            SHR:  begin v = a >> 1; c = a[0]; end
`ifdef ALU_MUL_EN
            MUL:  begin t = int'(a) * int'(b); v = 8'(t); c = (t > 255); end
`endif
            default: legal = 1'b0;
        endcase
        if (legal) begin
            if (d) s_m = v;
            else   r_m = v;
        end
        exp_q.push_back({r_m, s_m, legal ? c : 1'b0, legal && (v == 8'h00), !legal});
    endtask

    task automatic issue(input math_t o, input logic [7:0] a, input logic [7:0] b, input logic d);
        in_valid = 1'b1;
        op  = o;
        x   = a;
        y   = b;
        dst = d;
        predict(o, a, b, d);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({r_out, s_out, done, carry, zero, err, in_ready} !== {8'h00, 8'h00, 5'b00001}) begin
            n_bad++;
            $display("FAIL reset_state: got r=%h s=%h done=%b c=%b z=%b e=%b rdy=%b want all 0, rdy=1",
                     r_out, s_out, done, carry, zero, err, in_ready);
        end
    endtask

    task automatic test_add();
        exp_t e;
        issue(ADD, 8'hF0, 8'h20, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL add_done: got %b want 1", done); end
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e) begin n_bad++; $display("FAIL add_result: got %h want %h", observed(), e); end
        n_cmp++;
        if ({r_out, s_out, carry, zero} !== {8'h10, 8'h00, 2'b10}) begin
            n_bad++;
            $display("FAIL add_const: got r=%h s=%h c=%b z=%b want r=10 s=00 c=1 z=0", r_out, s_out, carry, zero);
        end
    endtask

    task automatic test_eq();
        exp_t e;
        issue(EQLN, 8'h3F, 8'h1F, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e || done !== 1'b1 || r_out !== 8'h01) begin
            n_bad++; $display("FAIL eqln: got %h done=%b want %h r=01 done=1", observed(), done, e);
        end
        issue(EQL, 8'h3F, 8'h1F, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e || done !== 1'b1 || {r_out, zero} !== {8'h00, 1'b1}) begin
            n_bad++; $display("FAIL eql: got %h done=%b want %h r=00 z=1 done=1", observed(), done, e);
        end
    endtask

    task automatic test_shift();
        exp_t e;
        issue(SHL, 8'h81, 8'hFF, 1'b1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e || done !== 1'b1) begin
            n_bad++; $display("FAIL shl: got %h done=%b want %h", observed(), done, e);
        end
        issue(SHR, 8'h81, 8'h00, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e || done !== 1'b1) begin
            n_bad++; $display("FAIL shr: got %h done=%b want %h", observed(), done, e);
        end
    endtask

    task automatic test_mul();
        exp_t e;
        issue(MUL, 8'd13, 8'd11, 1'b0);
`ifdef ALU_MUL_EN
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            // a competing request at t+3 and a dst flip must both be ignored
            in_valid = (k == 3);
            if (k == 3) begin op = ADD; x = 8'h01; y = 8'h01; dst = 1'b1; end
            n_cmp++;
            if ({in_ready, done} !== {(k >= 8), (k == 8)}) begin
                n_bad++;
                $display("FAIL mul_timing[t+%0d]: got rdy=%b done=%b want rdy=%b done=%b",
                         k, in_ready, done, (k >= 8), (k == 8));
            end
            if (k == 8) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (observed() !== e || {r_out, carry} !== {8'h8F, 1'b0}) begin
                    n_bad++; $display("FAIL mul_result: got %h want %h (r=8f c=0)", observed(), e);
                end
            end
        end
`else
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({done, err, in_ready} !== 3'b111 || observed() !== e) begin
            n_bad++;
            $display("FAIL mul_disabled: got done=%b err=%b rdy=%b out=%h want 1 1 1 out=%h",
                     done, err, in_ready, observed(), e);
        end
`endif
    endtask

    task automatic test_reset_mid();
        exp_t e;
`ifdef ALU_MUL_EN
        in_valid = 1'b1; op = MUL; x = 8'd200; y = 8'd3; dst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_cmp++;
            if (done !== 1'b0) begin n_bad++; $display("FAIL rst_mul_done[t+%0d]: got %b want 0", k, done); end
        end
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({r_out, s_out, done, carry, zero, err} !== 20'h0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got r=%h s=%h done=%b c=%b z=%b e=%b want all 0",
                     r_out, s_out, done, carry, zero, err);
        end
        reset = 1'b0;
        r_m = 8'h00;
        s_m = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({in_ready, done} !== 2'b10) begin
                n_bad++; $display("FAIL rst_mid_idle[%0d]: got rdy=%b done=%b want rdy=1 done=0", k, in_ready, done);
            end
        end
        issue(ADD, 8'h01, 8'h01, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e || done !== 1'b1 || r_out !== 8'h02) begin
            n_bad++; $display("FAIL rst_mid_add: got %h done=%b want %h r=02", observed(), done, e);
        end
    endtask

    task automatic test_illegal();
        exp_t  e;
        math_t bad_op;
        bad_op = math_t'(3'd7);
        issue(bad_op, 8'hAA, 8'h55, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({done, err} !== 2'b11 || observed() !== e) begin
            n_bad++; $display("FAIL illegal: got done=%b out=%h want done=1 out=%h", done, observed(), e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        math_t      ops [4];
        logic [7:0] xs  [4];
        logic [7:0] ys  [4];
        logic       ds  [4];
        ops[0] = ADD; xs[0] = 8'h01; ys[0] = 8'h02; ds[0] = 1'b0;
        ops[1] = ADD; xs[1] = 8'hFF; ys[1] = 8'h01; ds[1] = 1'b0;
        ops[2] = SUB; xs[2] = 8'h05; ys[2] = 8'h07; ds[2] = 1'b1;
        ops[3] = SUB; xs[3] = 8'h07; ys[3] = 8'h07; ds[3] = 1'b1;
        issue(ops[0], xs[0], ys[0], ds[0]);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done[%0d]: got %b want 1", i - 1, done); end
            e = exp_q.pop_front();
            n_cmp++;
            if (observed() !== e) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i - 1, observed(), e); end
            if (i == 3) begin
                n_cmp++;
                if ({s_out, carry} !== {8'hFE, 1'b0}) begin
                    n_bad++; $display("FAIL sub_borrow: got s=%h c=%b want s=fe c=0", s_out, carry);
                end
            end
            if (i < 4) issue(ops[i], xs[i], ys[i], ds[i]);
            else       in_valid = 1'b0;
        end
        n_cmp++;
        if ({s_out, carry, zero} !== {8'h00, 2'b11}) begin
            n_bad++; $display("FAIL sub_equal: got s=%h c=%b z=%b want s=00 c=1 z=1", s_out, carry, zero);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got done=%b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_eq();
        test_shift();
        test_mul();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
